// File: rtl/vga_pkg.sv
// Shared constants, types and the pixel-address helper for the frame-buffer controller.
package vga_pkg;

   localparam int unsigned VGA_H_RES = 640;
   localparam int unsigned VGA_V_RES = 480;
   localparam int unsigned COL_W     = 4;
   localparam int unsigned ADDR_W    = 19;
   localparam int unsigned COORD_W   = 10;

   typedef logic [COL_W-1:0]   col_t;
   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [COORD_W-1:0] coord_t;

   // One buffered CPU pixel write: linear address plus colour (23 bits).
   typedef struct packed {
      addr_t addr;
      col_t  col;
   } wr_req_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

   // y*640 + x as two shifts and adds: y*512 + y*128 + x.
   function automatic addr_t pix_addr(input coord_t x, input coord_t y);
      return (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7) + ADDR_W'(x);
   endfunction

endpackage

// File: rtl/vram_ctrl_if.sv
// Display-read, CPU-write and screen-clear signals between the frame buffer and its users.
interface vram_ctrl_if;
   import vga_pkg::*;

   logic   rd_en;
   coord_t rd_x;
   coord_t rd_y;
   col_t   rd_col;

   logic   wr_valid;
   logic   wr_ready;
   coord_t wr_x;
   coord_t wr_y;
   col_t   wr_col;

   logic   clr_req;
   col_t   clr_col;
   logic   clr_busy;

   modport master (
      output rd_en, rd_x, rd_y,
      output wr_valid, wr_x, wr_y, wr_col,
      output clr_req, clr_col,
      input  rd_col, wr_ready, clr_busy
   );

   modport slave (
      input  rd_en, rd_x, rd_y,
      input  wr_valid, wr_x, wr_y, wr_col,
      input  clr_req, clr_col,
      output rd_col, wr_ready, clr_busy
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags; DEPTH must be a power of two (>= 2).
module sync_fifo #(
   parameter int unsigned DW    = 23,
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [DW-1:0] data_i,
   input  logic          pop_i,
   output logic [DW-1:0] data_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DW-1:0] buf_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          full_q;
   logic          empty_q;
   logic          push_ok;
   logic          pop_ok;

   assign push_ok = push_i && !full_q;
   assign pop_ok  = pop_i && !empty_q;

   // Simultaneous push and pop leaves the occupancy unchanged.
   always_comb begin
      cnt_d = cnt_q;
      if (push_ok && !pop_ok) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == CW'(DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) buf_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = buf_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/vram_ctrl.sv
// 4-bit frame buffer: single-port pixel array shared by display reads, a screen-clear
// engine and a buffered CPU write channel (priority read > clear > CPU write).
module vram_ctrl
   import vga_pkg::*;
#(
   parameter int unsigned H_RES      = VGA_H_RES,
   parameter int unsigned V_RES      = VGA_V_RES,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   vram_ctrl_if.slave bus
);

   localparam int unsigned NPIX     = H_RES * V_RES;
   localparam int unsigned REQ_W    = $bits(wr_req_t);
   localparam coord_t      H_LIM    = COORD_W'(H_RES);
   localparam coord_t      V_LIM    = COORD_W'(V_RES);
   localparam addr_t       CLR_LAST = ADDR_W'(NPIX - 1);

   // Shift-add form for the standard 640-wide raster, plain product otherwise.
   function automatic addr_t xy_to_addr(input coord_t x, input coord_t y);
      if (H_RES == VGA_H_RES) return pix_addr(x, y);
      return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
   endfunction

   col_t       mem_q [NPIX];

   clr_state_e state_q;
   addr_t      clr_cnt_q;
   col_t       clr_col_q;
   logic       clr_busy_q;
   col_t       rd_col_q;

   logic       rd_hit;
   addr_t      rd_addr;
   logic       wr_in_range;
   logic       fifo_push;
   logic       fifo_pop;
   logic       fifo_full;
   logic       fifo_empty;
   wr_req_t    fifo_din;
   wr_req_t    fifo_head;

   logic       mem_we;
   addr_t      mem_waddr;
   col_t       mem_wdata;

   assign rd_hit  = bus.rd_en && (bus.rd_x < H_LIM) && (bus.rd_y < V_LIM);
   assign rd_addr = xy_to_addr(bus.rd_x, bus.rd_y);

   // Out-of-range beats are handshaken but never enqueued.
   assign wr_in_range = (bus.wr_x < H_LIM) && (bus.wr_y < V_LIM);
   assign fifo_push   = bus.wr_valid && !fifo_full && wr_in_range;
   assign fifo_din    = '{addr: xy_to_addr(bus.wr_x, bus.wr_y), col: bus.wr_col};
   assign fifo_pop    = !bus.rd_en && (state_q == ST_IDLE) && !fifo_empty;

   sync_fifo #(
      .DW    (REQ_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .push_i  (fifo_push),
      .data_i  (fifo_din),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Array write port: clear engine first, then the FIFO head, only when the display is idle.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (!bus.rd_en) begin
         if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = clr_col_q;
         end else if (!fifo_empty) begin
            mem_we    = 1'b1;
            mem_waddr = fifo_head.addr;
            mem_wdata = fifo_head.col;
         end
      end
   end

   // Pixel storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_col_q <= '0;
      end else begin
         rd_col_q <= rd_hit ? mem_q[rd_addr] : '0;
      end
   end

   // Clear engine: walks every address once, stalling whenever the display owns the array.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         clr_cnt_q  <= '0;
         clr_col_q  <= '0;
         clr_busy_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.clr_req) begin
                  state_q    <= ST_CLEAR;
                  clr_cnt_q  <= '0;
                  clr_col_q  <= bus.clr_col;
                  clr_busy_q <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (!bus.rd_en) begin
                  if (clr_cnt_q == CLR_LAST) begin
                     state_q    <= ST_IDLE;
                     clr_cnt_q  <= '0;
                     clr_busy_q <= 1'b0;
                  end else begin
                     clr_cnt_q <= clr_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               clr_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_col   = rd_col_q;
   assign bus.wr_ready = !fifo_full;
   assign bus.clr_busy = clr_busy_q;

endmodule

// File: tb/tb_vram_ctrl.sv
// Random and directed stimulus for vram_ctrl, checked every cycle against a queue/array model.
module tb_vram_ctrl;

   localparam int TB_H  = 640;
   localparam int TB_V  = 24;
   localparam int DEPTH = 4;
   localparam int NPIX  = TB_H * TB_V;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   vram_ctrl_if bus_if ();

   vram_ctrl #(
      .H_RES      (TB_H),
      .V_RES      (TB_V),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a;
      int c;
   } req_t;

   int   n_chk = 0;
   int   n_err = 0;

   byte unsigned m_mem [NPIX];
   req_t m_q[$];
   bit   m_clr;
   int   m_pos;
   int   m_ccol;
   int   m_rd;
   bit   m_ready;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_rng(input int x, input int y);
      return (x < TB_H) && (y < TB_V);
   endfunction

   task automatic m_reset();
      m_clr   = 1'b0;
      m_pos   = 0;
      m_q.delete();
      m_ready = 1'b1;
      m_rd    = 0;
   endtask

   // Behaviour of one clock edge, from the inputs present at that edge.
   task automatic model_edge();
      bit   was_clr = m_clr;
      bit   acc     = bus_if.wr_valid && m_ready;
      int   rx      = int'(bus_if.rd_x);
      int   ry      = int'(bus_if.rd_y);
      int   wx      = int'(bus_if.wr_x);
      int   wy      = int'(bus_if.wr_y);
      req_t r;
      if (bus_if.rd_en) m_rd = in_rng(rx, ry) ? int'(m_mem[ry * TB_H + rx]) : 0;
      else              m_rd = 0;
      if (!bus_if.rd_en) begin
         if (was_clr) begin
            m_mem[m_pos] = 8'(m_ccol);
            if (m_pos == NPIX - 1) m_clr = 1'b0;
            else                   m_pos++;
         end else if (m_q.size() != 0) begin
            r = m_q.pop_front();
            m_mem[r.a] = 8'(r.c);
         end
      end
      if (!was_clr && bus_if.clr_req) begin
         m_clr  = 1'b1;
         m_pos  = 0;
         m_ccol = int'(bus_if.clr_col);
      end
      if (acc && in_rng(wx, wy)) begin
         r.a = wy * TB_H + wx;
         r.c = int'(bus_if.wr_col);
         m_q.push_back(r);
      end
      m_ready = (m_q.size() < DEPTH);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("rd_col", 32'(bus_if.rd_col), 32'(m_rd));
      chk("wr_ready", 32'(bus_if.wr_ready), 32'(m_ready));
      chk("clr_busy", 32'(bus_if.clr_busy), 32'(m_clr));
   endtask

   task automatic set_idle();
      bus_if.rd_en    = 1'b0;
      bus_if.wr_valid = 1'b0;
      bus_if.clr_req  = 1'b0;
   endtask

   task automatic rd_pix(input int x, input int y);
      bus_if.rd_en = 1'b1;
      bus_if.rd_x  = 10'(x);
      bus_if.rd_y  = 10'(y);
      step();
      bus_if.rd_en = 1'b0;
   endtask

   function automatic logic [9:0] rnd_coord(input int lim, input bit oor);
      return oor ? 10'($urandom_range(1023, lim)) : 10'($urandom_range(lim - 1, 0));
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int busy_cnt;
      bus_if.rd_x = '0;  bus_if.rd_y = '0;
      bus_if.wr_x = '0;  bus_if.wr_y = '0;  bus_if.wr_col = '0;
      bus_if.clr_col = '0;
      set_idle();
      m_reset();

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_col", 32'(bus_if.rd_col), 32'd0);
      chk("rst_wr_ready", 32'(bus_if.wr_ready), 32'd1);
      chk("rst_clr_busy", 32'(bus_if.clr_busy), 32'd0);
      reset_n = 1'b1;

      // Full clear to colour 3 with the display idle.
      bus_if.clr_col = 4'd3;
      bus_if.clr_req = 1'b1;
      step();
      busy_cnt = bus_if.clr_busy ? 1 : 0;
      bus_if.clr_req = 1'b0;
      for (int i = 0; i < 2 * NPIX && bus_if.clr_busy; i++) begin
         step();
         if (bus_if.clr_busy) busy_cnt++;
      end
      chk("clr_cycles", 32'(busy_cnt), 32'(NPIX));
      rd_pix(0, 0);
      chk("clr_px_first", 32'(bus_if.rd_col), 32'd3);
      rd_pix(TB_H - 1, TB_V - 1);
      chk("clr_px_last", 32'(bus_if.rd_col), 32'd3);

      // Read after write.
      bus_if.wr_valid = 1'b1;
      bus_if.wr_x = 10'd10;  bus_if.wr_y = 10'd20;  bus_if.wr_col = 4'd5;
      step();
      bus_if.wr_valid = 1'b0;
      step();
      step();
      rd_pix(10, 20);
      chk("raw_px", 32'(bus_if.rd_col), 32'd5);

      // Back-pressure while the display holds the array.
      bus_if.rd_en = 1'b1;  bus_if.rd_x = '0;  bus_if.rd_y = '0;
      for (int i = 0; i < 5; i++) begin
         bus_if.wr_valid = 1'b1;
         bus_if.wr_x = 10'(100 + i);  bus_if.wr_y = 10'd5;  bus_if.wr_col = 4'(8 + i);
         step();
         if (i == 2) chk("bp_ready_high", 32'(bus_if.wr_ready), 32'd1);
         if (i == 3) chk("bp_ready_low", 32'(bus_if.wr_ready), 32'd0);
      end
      set_idle();
      repeat (4) step();
      chk("bp_ready_back", 32'(bus_if.wr_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         rd_pix(100 + i, 5);
         chk("bp_px", 32'(bus_if.rd_col), 32'(8 + i));
      end
      rd_pix(104, 5);
      chk("bp_px_refused", 32'(bus_if.rd_col), 32'd3);

      // Out-of-range write must not occupy a FIFO slot or alias onto (0,1).
      bus_if.rd_en = 1'b1;  bus_if.rd_x = '0;  bus_if.rd_y = 10'd1;
      bus_if.wr_valid = 1'b1;
      bus_if.wr_x = 10'd640;  bus_if.wr_y = 10'd0;  bus_if.wr_col = 4'd7;
      step();
      for (int i = 0; i < 4; i++) begin
         bus_if.wr_x = 10'(200 + i);  bus_if.wr_y = 10'd6;  bus_if.wr_col = 4'd1;
         step();
         if (i == 2) chk("oor_not_queued", 32'(bus_if.wr_ready), 32'd1);
         if (i == 3) chk("oor_full_after4", 32'(bus_if.wr_ready), 32'd0);
      end
      set_idle();
      repeat (4) step();
      rd_pix(0, 1);
      chk("oor_px01", 32'(bus_if.rd_col), 32'd3);

      // Random mix of display reads and CPU writes.
      for (int i = 0; i < 2000; i++) begin
         bus_if.rd_en    = ($urandom_range(2, 0) == 0);
         bus_if.rd_x     = rnd_coord(TB_H, $urandom_range(15, 0) == 0);
         bus_if.rd_y     = rnd_coord(TB_V, $urandom_range(15, 0) == 0);
         bus_if.wr_valid = $urandom_range(1, 0) == 1;
         bus_if.wr_x     = rnd_coord(TB_H, $urandom_range(7, 0) == 0);
         bus_if.wr_y     = rnd_coord(TB_V, $urandom_range(7, 0) == 0);
         bus_if.wr_col   = 4'($urandom);
         step();
      end
      set_idle();
      repeat (8) step();

      // Clear to colour 2 with interleaved reads, a mid-clear write and ignored clr_req.
      bus_if.clr_col = 4'd2;
      bus_if.clr_req = 1'b1;
      step();
      for (int i = 0; i < 4 * NPIX && bus_if.clr_busy; i++) begin
         bus_if.rd_en    = ($urandom_range(3, 0) == 0);
         bus_if.rd_x     = rnd_coord(TB_H, 1'b0);
         bus_if.rd_y     = rnd_coord(TB_V, 1'b0);
         bus_if.wr_valid = (i == 1000);
         bus_if.wr_x     = 10'd1;  bus_if.wr_y = 10'd1;  bus_if.wr_col = 4'd9;
         bus_if.clr_req  = ($urandom_range(63, 0) == 0);
         bus_if.clr_col  = 4'($urandom);
         step();
      end
      set_idle();
      repeat (3) step();
      rd_pix(1, 1);
      chk("wdc_px11", 32'(bus_if.rd_col), 32'd9);
      rd_pix(2, 1);
      chk("wdc_px21", 32'(bus_if.rd_col), 32'd2);

      // Asynchronous reset in the middle of a clear.
      bus_if.clr_col = 4'd6;
      bus_if.clr_req = 1'b1;
      step();
      bus_if.clr_req = 1'b0;
      repeat (300) step();
      bus_if.rd_en = 1'b1;  bus_if.rd_x = '0;  bus_if.rd_y = '0;
      step();
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_clr_busy", 32'(bus_if.clr_busy), 32'd0);
      chk("arst_rd_col", 32'(bus_if.rd_col), 32'd0);
      chk("arst_wr_ready", 32'(bus_if.wr_ready), 32'd1);
      m_reset();
      set_idle();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      rd_pix(0, 0);
      chk("arst_px_cleared", 32'(bus_if.rd_col), 32'd6);
      rd_pix(TB_H - 1, TB_V - 1);
      chk("arst_px_kept", 32'(bus_if.rd_col), 32'd2);
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/vram_ctrl.md
VRAM_CTRL -- requirements
Module: vram_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 640, visible width in pixels.
REQ-002 SHALL have parameter V_RES, default 480, visible height in lines.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, depth of the write-request buffer (power of 2).
REQ-004 SHALL have port clk  input  1  sole clock (50MHz), all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port rd_en  input  1  display fetch strobe.
REQ-007 SHALL have ports rd_x, rd_y  input  10 each  display pixel coordinate.
REQ-008 SHALL have port rd_col  output  4  pixel colour returned to the display stage.
REQ-009 SHALL have ports wr_valid (input, 1), wr_ready (output, 1), wr_x and wr_y (input, 10 each), wr_col (input, 4), the CPU pixel-write channel.
REQ-010 SHALL have ports clr_req (input, 1), clr_col (input, 4) and clr_busy (output, 1), the screen-clear control.

Function
REQ-011 SHALL hold H_RES*V_RES 4-bit pixels in one single-port array; pixel address = y*H_RES + x, 19 bits, computed without a multiplier for the default (y<<9 + y<<7 + x).
REQ-012 SHALL perform at most one array access per cycle; priority: display read > clear write > FIFO write.
REQ-013 SHALL, when rd_en=1 at edge N, present the stored colour of (rd_x, rd_y) on rd_col after edge N+1 (latency 1), and SHALL drive rd_col=0 after any edge where rd_en=0.
REQ-014 SHALL return rd_col=0 for out-of-range read coordinates (x>=H_RES or y>=V_RES) without accessing the array.
REQ-015 SHALL accept a write-channel beat when wr_valid=1 and wr_ready=1 at the same edge; wr_ready = not FIFO full.
REQ-016 SHALL drop, not enqueue, accepted beats with x>=H_RES or y>=V_RES.
REQ-017 SHALL retire the FIFO head to the array only in a cycle with rd_en=0 and clear FSM in IDLE; enqueue and dequeue in the same cycle SHALL leave the occupancy unchanged.
REQ-018 SHALL implement a clear FSM with states IDLE and CLEAR.
REQ-019 SHALL move IDLE->CLEAR on clr_req=1, latch clr_col, zero the clear address counter, and set clr_busy=1 on the same edge.
REQ-020 SHALL, in CLEAR, write the latched colour at the counter address and increment the counter in each cycle with rd_en=0, and stall the counter in cycles with rd_en=1.
REQ-021 SHALL move CLEAR->IDLE and drop clr_busy on the edge that writes address H_RES*V_RES-1.
REQ-022 SHALL ignore clr_req while in CLEAR.
REQ-023 SHALL keep accepting write beats into the FIFO while in CLEAR; those beats SHALL land after the clear completes, so they overwrite the cleared colour.

Reset
REQ-024 SHALL, while reset_n=0, force rd_col=0, clr_busy=0, FSM=IDLE, counter=0, FIFO empty, and wr_ready=1.
REQ-025 SHALL, on reset mid-clear, abandon the clear and leave partially cleared array contents as they are.
REQ-026 SHALL NOT reset the array contents.

Structure
REQ-027 SHALL place H_RES, V_RES, colour width (4), address width (19) and FSM state encodings in a shared package vga_pkg.
REQ-028 SHALL implement the write buffer as one sub-module, sync_fifo (parameters: data width 23 = 19-bit address + 4-bit colour, and depth).

Verification
REQ-029 SHALL cover read-after-write: write (10,20) col 5, wait 2 idle cycles, then rd_en=1 at (10,20) -> rd_col=5 one cycle later.
REQ-030 SHALL cover back-pressure: hold rd_en=1 and issue 5 writes -> wr_ready=0 after 4 accepted beats; drop rd_en -> all 4 beats land in the array, wr_ready returns to 1.
REQ-031 SHALL cover clear timing: clr_req with clr_col=3 and rd_en=0 -> clr_busy high for 307200 cycles; reads of (0,0) and (639,479) return 3.
REQ-032 SHALL cover out-of-range writes: write to (640,0) col 7 -> FIFO occupancy unchanged and (0,1) unchanged.
REQ-033 SHALL cover write during clear: write (1,1) col 9 mid-clear with clr_col 2 -> after clr_busy falls, (1,1) reads 9 and (2,1) reads 2.
REQ-034 SHALL cover async reset mid-clear: reset_n=0 mid-cycle -> clr_busy=0 and rd_col=0 immediately, no clock edge required.
